// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU constants for the register-file writeback path.
package rf_wb_arbiter_pkg;

    // Default data and register-address widths.
    localparam int unsigned DefDw = 32;
    localparam int unsigned DefAw = 5;

    // Requester indices into the grant vector.
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MC  = 1;

    // One bit per requester, indexed by REQ_ALU / REQ_MC.
    typedef logic [1:0] req_vec_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  req_vec_t req_i,
    output req_vec_t gnt_o
);

    // 0 = requester 0 granted most recently, 1 = requester 1.
    logic last_q, last_d;

    // Grant the lone requester, or on a tie the one not granted last.
    // Grants are held off while reset is asserted.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (rstn) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o[REQ_ALU]) begin
            last_d = 1'b0;
        end else if (gnt_o[REQ_MC]) begin
            last_d = 1'b1;
        end
    end

    // Last-grant register; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with a long-latency pending scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned AW = DefAw
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_data,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_data,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] q_ra0,
    input  logic [AW-1:0] q_ra1,
    output logic          q_busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd
);

    localparam int unsigned NReg = 1 << AW;

    req_vec_t req, gnt;
    logic     hs0, hs1, iss_hs;

    logic            we_q, we_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic [NReg-1:0] pend_q, pend_d;

    assign req[REQ_ALU] = r0_valid;
    assign req[REQ_MC]  = r1_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .req_i (req),
        .gnt_o (gnt)
    );

    // Handshake and query outputs; readiness never depends on write data.
    always_comb begin
        r0_ready  = gnt[REQ_ALU];
        r1_ready  = gnt[REQ_MC];
        iss_ready = rstn & ~pend_q[iss_rd];
        q_busy    = pend_q[q_ra0] | pend_q[q_ra1];
        hs0       = r0_valid & r0_ready;
        hs1       = r1_valid & r1_ready;
        iss_hs    = iss_valid & iss_ready & (iss_rd != '0);
    end

    // Next write-port and scoreboard state.
    always_comb begin
        we_d   = 1'b0;
        wa_d   = wa_q;
        wd_d   = wd_q;
        pend_d = pend_q;
        if (hs0) begin
            we_d = (r0_addr != '0);
            wa_d = r0_addr;
            wd_d = r0_data;
        end else if (hs1) begin
            we_d = (r1_addr != '0);
            wa_d = r1_addr;
            wd_d = r1_data;
        end
        if (hs1) begin
            pend_d[r1_addr] = 1'b0;
        end
        // iss_ready blocks an issue to a pending register, so a same-register
        // set/clear cannot collide; register 0 is never marked.
        if (iss_hs) begin
            pend_d[iss_rd] = 1'b1;
        end
    end

    // Write-port and scoreboard registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            pend_q <= '0;
        end else begin
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
        end
    end

    assign rf_we = we_q;
    assign rf_wa = wa_q;
    assign rf_wd = wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter with a behavioural model.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic        r0_valid, r0_ready;
    logic [4:0]  r0_addr;
    logic [31:0] r0_data;
    logic        r1_valid, r1_ready;
    logic [4:0]  r1_addr;
    logic [31:0] r1_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd;
    logic [4:0]  q_ra0, q_ra1;
    logic        q_busy;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    rf_wb_arbiter #(.DW(32), .AW(5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_addr   (r0_addr),
        .r0_data   (r0_data),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_addr   (r1_addr),
        .r1_data   (r1_data),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .q_ra0     (q_ra0),
        .q_ra1     (q_ra1),
        .q_busy    (q_busy),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int          m_last;   // requester granted most recently
    bit [31:0]   m_pend;   // registers awaiting a requester-1 writeback
    bit          m_we;
    bit [4:0]    m_wa;
    bit [31:0]   m_wd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_pend = '0;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                        input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                        input bit iv, input bit [4:0] ird,
                        input bit [4:0] qa0, input bit [4:0] qa1);
        bit g0, g1, ir;
        @(negedge clk);
        r0_valid = v0; r0_addr = a0; r0_data = d0;
        r1_valid = v1; r1_addr = a1; r1_data = d1;
        iss_valid = iv; iss_rd = ird; q_ra0 = qa0; q_ra1 = qa1;
        #1;
        if (v0 && v1) g0 = (m_last == 1);
        else          g0 = v0;
        g1 = v1 && !g0;
        ir = !m_pend[ird];
        check_eq("r0_ready", 32'(r0_ready), 32'(g0));
        check_eq("r1_ready", 32'(r1_ready), 32'(g1));
        check_eq("iss_ready", 32'(iss_ready), 32'(ir));
        check_eq("q_busy", 32'(q_busy), 32'(m_pend[qa0] | m_pend[qa1]));
        check_eq("rf_we", 32'(rf_we), 32'(m_we));
        check_eq("rf_wa", 32'(rf_wa), 32'(m_wa));
        check_eq("rf_wd", rf_wd, m_wd);
        if (g0) begin
            m_we = (a0 != 0); m_wa = a0; m_wd = d0; m_last = 0;
        end else if (g1) begin
            m_we = (a1 != 0); m_wa = a1; m_wd = d1; m_last = 1;
            m_pend[a1] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (iv && ir && ird != 0) m_pend[ird] = 1'b1;
    endtask

    task automatic idle(input bit [4:0] qa0, input bit [4:0] qa1);
        step(0, 0, 0, 0, 0, 0, 0, 0, qa0, qa1);
    endtask

    // Asynchronous reset pulse in mid-cycle with every requester asking.
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
        q_ra0 = 5'd3; q_ra1 = 5'd3;
        #1;
        check_eq("rst_rf_we", 32'(rf_we), 32'd0);
        check_eq("rst_rf_wa", 32'(rf_wa), 32'd0);
        check_eq("rst_rf_wd", rf_wd, 32'd0);
        check_eq("rst_q_busy", 32'(q_busy), 32'd0);
        check_eq("rst_r0_ready", 32'(r0_ready), 32'd0);
        check_eq("rst_r1_ready", 32'(r1_ready), 32'd0);
        check_eq("rst_iss_ready", 32'(iss_ready), 32'd0);
        model_reset();
        r0_valid = 1'b0; r1_valid = 1'b0; iss_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bit v0, v1, iv;
        bit [4:0] a0, a1, ird;
        model_reset();
        rstn = 1'b0;
        r0_valid = 0; r0_addr = 0; r0_data = 0;
        r1_valid = 0; r1_addr = 0; r1_data = 0;
        iss_valid = 0; iss_rd = 0; q_ra0 = 0; q_ra1 = 0;
        #2;
        check_eq("init_rf_we", 32'(rf_we), 32'd0);
        check_eq("init_rf_wa", 32'(rf_wa), 32'd0);
        check_eq("init_rf_wd", rf_wd, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Both valid for four cycles: grants alternate starting with requester 0.
        for (int i = 0; i < 4; i++) begin
            step(1, 5'(10 + i), 32'(100 + i), 1, 5'(20 + i), 32'(200 + i), 0, 0, 0, 0);
            check_eq("rr_r0_ready", 32'(r0_ready), 32'((i % 2) == 0));
        end
        idle(0, 0);
        check_eq("rr_last_wa", 32'(rf_wa), 32'd23);

        // Single requester 0 write.
        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        check_eq("wr_r0_ready", 32'(r0_ready), 32'd1);
        idle(0, 0);
        check_eq("wr_rf_we", 32'(rf_we), 32'd1);
        check_eq("wr_rf_wa", 32'(rf_wa), 32'd5);
        check_eq("wr_rf_wd", rf_wd, 32'h1234);

        // Issue rd=7, then requester 1 writes it back.
        step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(7, 0);
        check_eq("sb_busy_set", 32'(q_busy), 32'd1);
        step(0, 0, 0, 1, 7, 32'hCAFE, 0, 0, 7, 0);
        idle(7, 0);
        check_eq("sb_busy_clr", 32'(q_busy), 32'd0);
        check_eq("sb_rf_we", 32'(rf_we), 32'd1);
        check_eq("sb_rf_wa", 32'(rf_wa), 32'd7);

        // Double issue to the same register, then issue to x0.
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        check_eq("dbl_iss_ready", 32'(iss_ready), 32'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_eq("x0_iss_ready", 32'(iss_ready), 32'd1);
        idle(0, 7);
        check_eq("x0_busy_7", 32'(q_busy), 32'd1);
        check_eq("x0_busy_0", 32'(dut.pend_q[0]), 32'd0);
        step(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0);

        // Write to x0 is accepted but suppressed.
        step(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        check_eq("x0_r0_ready", 32'(r0_ready), 32'd1);
        idle(0, 0);
        check_eq("x0_rf_we", 32'(rf_we), 32'd0);

        // Reset mid-stream with pending[3] set and last grant on requester 0.
        step(1, 2, 32'h22, 0, 0, 0, 1, 3, 0, 0);
        idle(3, 0);
        check_eq("pre_rst_busy", 32'(q_busy), 32'd1);
        pulse_reset();
        step(1, 4, 32'h44, 1, 6, 32'h66, 0, 0, 3, 0);
        check_eq("post_rst_r0_ready", 32'(r0_ready), 32'd1);
        check_eq("post_rst_r1_ready", 32'(r1_ready), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            v0  = 1'($urandom_range(0, 1));
            v1  = 1'($urandom_range(0, 1));
            iv  = 1'($urandom_range(0, 1));
            a0  = 5'($urandom_range(0, 31));
            a1  = 5'($urandom_range(0, 7));
            ird = 5'($urandom_range(0, 7));
            if (v1 && a1 == ird) iv = 1'b0;
            step(v0, a0, $urandom, v1, a1, $urandom, iv, ird,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
